object_engine: RTL and testbench
================================

Name: object_engine

Overview:
- Parametrised successor to the fixed two-player graphics path in the console peripherals.
- Serialises NUM_OBJECTS movable objects (players, missiles, ball) against the HDMI horizontal position.
- Resolves fixed-priority colour per pixel and latches pairwise collisions for the CPU to read.
- Sits between the CPU register bus and the hdmi colour input; the peripherals decoder forwards its address window to this block.

Parameters:
NUM_OBJECTS, 4, object count, 2..8
POS_WIDTH, 10, width of hpos and object X positions, 9..12
DATA_WIDTH, 8, graphics bits per object line, 1..8
COLOR_WIDTH, 7, colour index width, ≤8

Ports:
raw_clk  in  1  system clock; all state on rising edge
reset_n  in  1  asynchronous active-low reset
write_enable  in  1  register write strobe, one raw_clk
enable  in  1  register read strobe; data_out updates next edge
address  in  6  register address
data_in  in  8  write data
data_out  out  8  read data, registered
hpos  in  POS_WIDTH  current horizontal pixel position
pixel_en  in  1  one-cycle pulse per pixel; hpos is valid with it
line_start  in  1  one-cycle pulse at start of each scanline
pixel_color  out  COLOR_WIDTH  resolved colour
pixel_hit  out  NUM_OBJECTS  per-object active bit for the current pixel

Behaviour:
- Register map, object i at 4*i+k:
  - k=0: posx[7:0].
  - k=1: bits[3:0] = posx[POS_WIDTH-1:8]; bits[5:4] = size (0:1x, 1:2x, 2:4x, 3:8x); bit6 = reflect; bit7 = vdel.
  - k=2: graphics[DATA_WIDTH-1:0].
  - k=3: colour, taken from data_in[7:8-COLOR_WIDTH].
- Common registers:
  - 0x20: enable mask, one bit per object.
  - 0x21: background colour.
  - 0x22: collision clear; any write clears the latch.
  - 0x24..0x27: read the collision pair vector, LSB first.
- Collision pair ordering: (0,1),(0,2)..(0,N-1),(1,2)..; NUM_OBJECTS*(NUM_OBJECTS-1)/2 bits; unused bits read 0.
- Unmapped reads return 0. Writes to unmapped or nonexistent-object addresses are ignored.
- Per-object serializer states: IDLE, SHIFT.
  - IDLE→SHIFT: on a pixel_en cycle where hpos==posx and the enable bit is set. Graphics and size are latched at that moment; bit index is MSB-first, or LSB-first when reflect=1.
  - Each bit is held for 2^size pixel_en cycles. After DATA_WIDTH<<size pixels → IDLE.
  - A trigger while in SHIFT restarts from the first bit.
  - Clearing the enable bit forces IDLE on the next edge.
  - Writes to graphics/size/reflect mid-SHIFT do not affect the object until its next trigger.
- Output pipeline: one register stage.
  - pixel_color and pixel_hit for the pixel at hpos=X are valid the raw_clk after that pixel_en. They hold between pixel_en pulses.
  - Trigger pixel X shows the first graphics bit.
- Priority: lowest object index with an active bit wins; if none, the background colour.
- Collision latch:
  - Set on each pixel_en where both objects of a pair are active. Sticky.
  - A clear write in the same cycle as a new hit leaves that bit set; all other bits clear.
- posx ≥ line width: the object never triggers, with no error.
- line_start: resets every serializer to IDLE, so no wrap into the next line. It also performs the VDELAY copy when that feature is compiled in.
- Reset: all registers, serializers, latches, data_out, pixel_color and pixel_hit go to 0 immediately. A reset mid-line leaves the block IDLE; objects retrigger on the next hpos match.

Optional Feature:
OBJECT_ENGINE_VDELAY_EN
- Defined: graphics writes to objects with vdel=1 go to a pending register, copied to the active graphics on the next line_start. Objects with vdel=0 write directly.
- Undefined: vdel bit is stored and read back but has no effect; writes always go directly. No pending storage is built.

Test Plan:
- obj0 posx=100, graphics=0xA5, size=0, enabled → pixel_hit[0] high at X=100,102,105,107 and low elsewhere in 100..107; pixel_color=obj0 colour on the hit pixels, background elsewhere.
- Same with size=2, reflect=1 → 32 pixels, bit pattern 1010 0101 reversed, each bit held 4 pixels, IDLE at X=132.
- obj0 and obj1 at posx=50, graphics 0xFF → colour = obj0's; pair bit0 at 0x24 reads 1. Write 0x22 → reads 0. Clear coincident with a new overlap → bit stays 1.
- Graphics write mid-SHIFT (X=103) → current pass unchanged; the new pattern appears on the next line's trigger.
- reset_n low at X=104 mid-object → outputs 0 immediately; after release, all registers read 0 and nothing displays until reprogrammed.
- VDELAY_EN defined, vdel=1: write 0x0F mid-line → display unchanged until after line_start, then 0x0F. Without the macro, 0x0F applies at the next trigger.

Source files
------------

// File: rtl/object_engine.sv
// object_engine: serialises NUM_OBJECTS movable objects against the horizontal
// pixel position, resolves fixed-priority colour and latches pairwise collisions.
// Optional build macro OBJECT_ENGINE_VDELAY_EN adds pending graphics registers
// that are copied to the active graphics on line_start for objects with vdel=1.
module object_engine #(
  parameter int NUM_OBJECTS = 4,
  parameter int POS_WIDTH   = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int COLOR_WIDTH = 7
) (
  input  logic                   raw_clk,
  input  logic                   reset_n,
  input  logic                   write_enable,
  input  logic                   enable,
  input  logic [5:0]             address,
  input  logic [7:0]             data_in,
  output logic [7:0]             data_out,
  input  logic [POS_WIDTH-1:0]   hpos,
  input  logic                   pixel_en,
  input  logic                   line_start,
  output logic [COLOR_WIDTH-1:0] pixel_color,
  output logic [NUM_OBJECTS-1:0] pixel_hit
);

  localparam int NPAIRS = NUM_OBJECTS * (NUM_OBJECTS - 1) / 2;
  // Enough to hold DATA_WIDTH << 3 (longest pass, 8x size).
  localparam int CNT_W  = $clog2(DATA_WIDTH * 8) + 1;

  typedef enum logic {S_IDLE, S_SHIFT} ser_state_t;

  // Programmable object registers
  logic [POS_WIDTH-1:0]   posx_q    [NUM_OBJECTS];
  logic [POS_WIDTH-1:0]   posx_d    [NUM_OBJECTS];
  logic [1:0]             size_q    [NUM_OBJECTS];
  logic [1:0]             size_d    [NUM_OBJECTS];
  logic [NUM_OBJECTS-1:0] reflect_q, reflect_d;
  logic [NUM_OBJECTS-1:0] vdel_q,    vdel_d;
  logic [DATA_WIDTH-1:0]  gfx_q     [NUM_OBJECTS];
  logic [DATA_WIDTH-1:0]  gfx_d     [NUM_OBJECTS];
  logic [COLOR_WIDTH-1:0] color_q   [NUM_OBJECTS];
  logic [COLOR_WIDTH-1:0] color_d   [NUM_OBJECTS];
  logic [NUM_OBJECTS-1:0] en_q,      en_d;
  logic [COLOR_WIDTH-1:0] bg_q,      bg_d;
  logic [NPAIRS-1:0]      coll_q,    coll_d;
`ifdef OBJECT_ENGINE_VDELAY_EN
  logic [DATA_WIDTH-1:0]  pend_q    [NUM_OBJECTS];
  logic [DATA_WIDTH-1:0]  pend_d    [NUM_OBJECTS];
  logic [NUM_OBJECTS-1:0] pend_vld_q, pend_vld_d;
`endif

  // Serializer state, snapshotted at trigger time
  ser_state_t             st_q      [NUM_OBJECTS];
  ser_state_t             st_d      [NUM_OBJECTS];
  logic [CNT_W-1:0]       cnt_q     [NUM_OBJECTS];
  logic [CNT_W-1:0]       cnt_d     [NUM_OBJECTS];
  logic [DATA_WIDTH-1:0]  sh_gfx_q  [NUM_OBJECTS];
  logic [DATA_WIDTH-1:0]  sh_gfx_d  [NUM_OBJECTS];
  logic [1:0]             sh_size_q [NUM_OBJECTS];
  logic [1:0]             sh_size_d [NUM_OBJECTS];
  logic [NUM_OBJECTS-1:0] sh_refl_q, sh_refl_d;

  // Output registers
  logic [NUM_OBJECTS-1:0] pixel_hit_q,   pixel_hit_d;
  logic [COLOR_WIDTH-1:0] pixel_color_q, pixel_color_d;
  logic [7:0]             data_out_q,    data_out_d;

  logic [NUM_OBJECTS-1:0] act;
  logic [NPAIRS-1:0]      pair_hit;
  logic [COLOR_WIDTH-1:0] pix_color;
  logic [7:0]             rd_data;
  logic                   clr_wr;

  assign data_out    = data_out_q;
  assign pixel_color = pixel_color_q;
  assign pixel_hit   = pixel_hit_q;
  assign clr_wr      = write_enable && (address == 6'h22);

  // Colour registers live in the top COLOR_WIDTH bits of the byte.
  function automatic logic [7:0] color_to_byte(input logic [COLOR_WIDTH-1:0] c);
    logic [COLOR_WIDTH+7:0] t;
    t = {c, 8'h00};
    return t[COLOR_WIDTH+7 -: 8];
  endfunction

  // Register file writes and the vertical-delay copy at line start
  always_comb begin
    posx_d    = posx_q;
    size_d    = size_q;
    reflect_d = reflect_q;
    vdel_d    = vdel_q;
    gfx_d     = gfx_q;
    color_d   = color_q;
    en_d      = en_q;
    bg_d      = bg_q;
`ifdef OBJECT_ENGINE_VDELAY_EN
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    for (int i = 0; i < NUM_OBJECTS; i++) begin
      if (line_start && vdel_q[i] && pend_vld_q[i]) begin
        gfx_d[i]      = pend_q[i];
        pend_vld_d[i] = 1'b0;
      end
    end
`endif
    if (write_enable) begin
      if (!address[5]) begin
        // Addresses of objects >= NUM_OBJECTS match no index and are dropped.
        for (int i = 0; i < NUM_OBJECTS; i++) begin
          if (address[4:2] == 3'(i)) begin
            case (address[1:0])
              2'd0: posx_d[i][7:0] = data_in;
              2'd1: begin
                posx_d[i][POS_WIDTH-1:8] = data_in[POS_WIDTH-9:0];
                size_d[i]    = data_in[5:4];
                reflect_d[i] = data_in[6];
                vdel_d[i]    = data_in[7];
              end
              2'd2: begin
`ifdef OBJECT_ENGINE_VDELAY_EN
                if (vdel_q[i]) begin
                  pend_d[i]     = data_in[DATA_WIDTH-1:0];
                  pend_vld_d[i] = 1'b1;
                end else begin
                  gfx_d[i] = data_in[DATA_WIDTH-1:0];
                end
`else
                gfx_d[i] = data_in[DATA_WIDTH-1:0];
`endif
              end
              default: color_d[i] = data_in[7 -: COLOR_WIDTH];
            endcase
          end
        end
      end else begin
        case (address)
          6'h20:   en_d = data_in[NUM_OBJECTS-1:0];
          6'h21:   bg_d = data_in[7 -: COLOR_WIDTH];
          default: ;
        endcase
      end
    end
  end

  // Register read mux; data_out only moves on a read strobe
  always_comb begin
    logic [31:0] coll32;
    coll32  = 32'(coll_q);
    rd_data = 8'h00;
    if (!address[5]) begin
      for (int i = 0; i < NUM_OBJECTS; i++) begin
        if (address[4:2] == 3'(i)) begin
          case (address[1:0])
            2'd0:    rd_data = posx_q[i][7:0];
            2'd1:    rd_data = {vdel_q[i], reflect_q[i], size_q[i],
                                4'(posx_q[i][POS_WIDTH-1:8])};
            2'd2:    rd_data = 8'(gfx_q[i]);
            default: rd_data = color_to_byte(color_q[i]);
          endcase
        end
      end
    end else begin
      case (address)
        6'h20:   rd_data = 8'(en_q);
        6'h21:   rd_data = color_to_byte(bg_q);
        6'h24:   rd_data = coll32[7:0];
        6'h25:   rd_data = coll32[15:8];
        6'h26:   rd_data = coll32[23:16];
        6'h27:   rd_data = coll32[31:24];
        default: rd_data = 8'h00;
      endcase
    end
    data_out_d = enable ? rd_data : data_out_q;
  end

  // Per-object serializers: trigger on position match, shift one bit per 2^size pixels
  always_comb begin
    logic             trig;
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] sel;
    logic [DATA_WIDTH-1:0] bits;
    st_d      = st_q;
    cnt_d     = cnt_q;
    sh_gfx_d  = sh_gfx_q;
    sh_size_d = sh_size_q;
    sh_refl_d = sh_refl_q;
    act       = '0;
    for (int i = 0; i < NUM_OBJECTS; i++) begin
      trig  = pixel_en && en_q[i] && (hpos == posx_q[i]);
      total = '0;
      idx   = '0;
      sel   = '0;
      bits  = '0;
      if (line_start || !en_q[i]) begin
        st_d[i] = S_IDLE;
      end else if (trig) begin
        // Trigger pixel already shows the first bit of the freshly latched pattern.
        sh_gfx_d[i]  = gfx_q[i];
        sh_size_d[i] = size_q[i];
        sh_refl_d[i] = reflect_q[i];
        act[i]       = reflect_q[i] ? gfx_q[i][0] : gfx_q[i][DATA_WIDTH-1];
        total        = CNT_W'(DATA_WIDTH) << size_q[i];
        cnt_d[i]     = CNT_W'(1);
        st_d[i]      = (total == CNT_W'(1)) ? S_IDLE : S_SHIFT;
      end else if (pixel_en && (st_q[i] == S_SHIFT)) begin
        idx      = cnt_q[i] >> sh_size_q[i];
        sel      = sh_refl_q[i] ? idx : (CNT_W'(DATA_WIDTH - 1) - idx);
        bits     = sh_gfx_q[i] >> sel;
        act[i]   = bits[0];
        total    = CNT_W'(DATA_WIDTH) << sh_size_q[i];
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
        if (cnt_d[i] == total) st_d[i] = S_IDLE;
      end
    end
  end

  // Priority colour, pair detection, output stage and collision latch
  always_comb begin
    int p;
    pix_color = bg_q;
    for (int i = NUM_OBJECTS - 1; i >= 0; i--) begin
      if (act[i]) pix_color = color_q[i];
    end
    pair_hit = '0;
    p = 0;
    for (int i = 0; i < NUM_OBJECTS; i++) begin
      for (int j = i + 1; j < NUM_OBJECTS; j++) begin
        pair_hit[p] = act[i] & act[j];
        p = p + 1;
      end
    end
    pixel_hit_d   = pixel_en ? act : pixel_hit_q;
    pixel_color_d = pixel_en ? pix_color : pixel_color_q;
    // A clear keeps only hits arriving in the same cycle.
    coll_d = clr_wr ? pair_hit : (coll_q | pair_hit);
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OBJECTS; i++) begin
        posx_q[i]    <= '0;
        size_q[i]    <= '0;
        gfx_q[i]     <= '0;
        color_q[i]   <= '0;
        st_q[i]      <= S_IDLE;
        cnt_q[i]     <= '0;
        sh_gfx_q[i]  <= '0;
        sh_size_q[i] <= '0;
`ifdef OBJECT_ENGINE_VDELAY_EN
        pend_q[i]    <= '0;
`endif
      end
`ifdef OBJECT_ENGINE_VDELAY_EN
      pend_vld_q    <= '0;
`endif
      reflect_q     <= '0;
      vdel_q        <= '0;
      sh_refl_q     <= '0;
      en_q          <= '0;
      bg_q          <= '0;
      coll_q        <= '0;
      pixel_hit_q   <= '0;
      pixel_color_q <= '0;
      data_out_q    <= '0;
    end else begin
      posx_q        <= posx_d;
      size_q        <= size_d;
      gfx_q         <= gfx_d;
      color_q       <= color_d;
      st_q          <= st_d;
      cnt_q         <= cnt_d;
      sh_gfx_q      <= sh_gfx_d;
      sh_size_q     <= sh_size_d;
`ifdef OBJECT_ENGINE_VDELAY_EN
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
`endif
      reflect_q     <= reflect_d;
      vdel_q        <= vdel_d;
      sh_refl_q     <= sh_refl_d;
      en_q          <= en_d;
      bg_q          <= bg_d;
      coll_q        <= coll_d;
      pixel_hit_q   <= pixel_hit_d;
      pixel_color_q <= pixel_color_d;
      data_out_q    <= data_out_d;
    end
  end

endmodule

// File: tb/tb_object_engine.sv
// Directed bench for object_engine with default parameters.
module tb_object_engine;

  logic       raw_clk = 1'b0;
  logic       reset_n;
  logic       write_enable;
  logic       enable;
  logic [5:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [9:0] hpos;
  logic       pixel_en;
  logic       line_start;
  logic [6:0] pixel_color;
  logic [3:0] pixel_hit;

  int n_cmp;
  int n_err;
  logic [7:0] r;
  logic [7:0] pat;

  localparam logic [6:0] C0 = 7'h41;  // obj0 colour, written as 0x82
  localparam logic [6:0] C1 = 7'h22;  // obj1 colour, written as 0x44
  localparam logic [6:0] BG = 7'h08;  // background, written as 0x10

  always #5 raw_clk = ~raw_clk;

  object_engine #(
    .NUM_OBJECTS(4), .POS_WIDTH(10), .DATA_WIDTH(8), .COLOR_WIDTH(7)
  ) dut (
    .raw_clk(raw_clk), .reset_n(reset_n), .write_enable(write_enable),
    .enable(enable), .address(address), .data_in(data_in), .data_out(data_out),
    .hpos(hpos), .pixel_en(pixel_en), .line_start(line_start),
    .pixel_color(pixel_color), .pixel_hit(pixel_hit)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge raw_clk);
    write_enable = 1'b1; address = a; data_in = d;
    @(negedge raw_clk);
    write_enable = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [7:0] d);
    @(negedge raw_clk);
    enable = 1'b1; address = a;
    @(negedge raw_clk);
    enable = 1'b0;
    d = data_out;
  endtask

  task automatic pix(input int x);
    @(negedge raw_clk);
    pixel_en = 1'b1; hpos = 10'(x);
    @(negedge raw_clk);
    pixel_en = 1'b0;
  endtask

  // Pixel with a collision-clear write in the very same cycle.
  task automatic pix_clr(input int x);
    @(negedge raw_clk);
    pixel_en = 1'b1; hpos = 10'(x);
    write_enable = 1'b1; address = 6'h22; data_in = 8'h00;
    @(negedge raw_clk);
    pixel_en = 1'b0; write_enable = 1'b0;
  endtask

  task automatic line();
    @(negedge raw_clk);
    line_start = 1'b1;
    @(negedge raw_clk);
    line_start = 1'b0;
  endtask

  // Drive pixel x and check obj0 alone against an expected on/off value.
  task automatic pix_obj0(input int x, input logic on, input logic [6:0] bg);
    pix(x);
    chk($sformatf("hit x=%0d", x), 32'(pixel_hit), on ? 32'h1 : 32'h0);
    chk($sformatf("col x=%0d", x), 32'(pixel_color), on ? 32'(C0) : 32'(bg));
  endtask

  function automatic logic msb_bit(input logic [7:0] p, input int k);
    return p[7 - k];
  endfunction

  initial begin
    n_cmp = 0; n_err = 0;
    reset_n = 1'b0; write_enable = 1'b0; enable = 1'b0; address = '0;
    data_in = '0; hpos = '0; pixel_en = 1'b0; line_start = 1'b0;
    repeat (3) @(negedge raw_clk);
    chk("rst hit", 32'(pixel_hit), 32'h0);
    chk("rst col", 32'(pixel_color), 32'h0);
    chk("rst dout", 32'(data_out), 32'h0);
    reset_n = 1'b1;
    rd(6'h00, r); chk("rst posx0", 32'(r), 32'h0);
    rd(6'h20, r); chk("rst enmask", 32'(r), 32'h0);
    rd(6'h24, r); chk("rst coll", 32'(r), 32'h0);

    // Basic object: 0xA5 at X=100, size 1x
    wr(6'h00, 8'h64); wr(6'h01, 8'h00); wr(6'h02, 8'hA5); wr(6'h03, 8'h82);
    wr(6'h21, 8'h10); wr(6'h20, 8'h01);
    rd(6'h03, r); chk("rd col0", 32'(r), 32'h82);
    rd(6'h02, r); chk("rd gfx0", 32'(r), 32'hA5);
    line();
    for (int x = 95; x <= 110; x++)
      pix_obj0(x, (x == 100) || (x == 102) || (x == 105) || (x == 107), BG);

    // 4x size with reflect: palindromic 0xA5 spans 32 pixels
    wr(6'h01, 8'h60);
    line();
    for (int x = 98; x <= 134; x++)
      pix_obj0(x, ((x >= 100) && (x <= 103)) || ((x >= 108) && (x <= 111)) ||
                  ((x >= 120) && (x <= 123)) || ((x >= 128) && (x <= 131)), BG);

    // Reflect on an asymmetric pattern: 0xC0 LSB-first lights the last two pixels
    wr(6'h01, 8'h40); wr(6'h02, 8'hC0);
    line();
    for (int x = 100; x <= 108; x++)
      pix_obj0(x, (x == 106) || (x == 107), BG);

    // Collisions: obj0, obj1, obj2 all at X=50
    wr(6'h00, 8'h32); wr(6'h01, 8'h00); wr(6'h02, 8'hFF);
    wr(6'h04, 8'h32); wr(6'h05, 8'h00); wr(6'h06, 8'hFF); wr(6'h07, 8'h44);
    wr(6'h08, 8'h32); wr(6'h09, 8'h00); wr(6'h0A, 8'h80); wr(6'h0B, 8'h20);
    wr(6'h20, 8'h07);
    line();
    pix(50);
    chk("ovl hit", 32'(pixel_hit), 32'h7);
    chk("ovl col", 32'(pixel_color), 32'(C0));
    rd(6'h24, r); chk("coll pairs", 32'(r), 32'h0B);
    rd(6'h25, r); chk("coll byte1", 32'(r), 32'h00);
    wr(6'h22, 8'h00);
    rd(6'h24, r); chk("coll clr", 32'(r), 32'h00);
    line();
    pix(50);
    rd(6'h24, r); chk("coll again", 32'(r), 32'h0B);
    pix_clr(51);
    chk("clr+hit hit", 32'(pixel_hit), 32'h3);
    rd(6'h24, r); chk("clr+hit coll", 32'(r), 32'h01);
    wr(6'h22, 8'h00);
    rd(6'h24, r); chk("coll clr2", 32'(r), 32'h00);
    wr(6'h20, 8'h06);
    line();
    pix(50);
    chk("prio hit", 32'(pixel_hit), 32'h6);
    chk("prio col", 32'(pixel_color), 32'(C1));

    // Graphics write mid-pass takes effect only at the next trigger
    wr(6'h20, 8'h01); wr(6'h00, 8'h64); wr(6'h02, 8'hA5);
    line();
    for (int x = 100; x <= 103; x++) pix_obj0(x, msb_bit(8'hA5, x - 100), BG);
    wr(6'h02, 8'h0F);
    for (int x = 104; x <= 107; x++) pix_obj0(x, msb_bit(8'hA5, x - 100), BG);
    line();
    for (int x = 100; x <= 107; x++) pix_obj0(x, msb_bit(8'h0F, x - 100), BG);

    // Asynchronous reset in the middle of an object
    line();
    for (int x = 100; x <= 104; x++) pix(x);
    chk("pre-rst hit", 32'(pixel_hit), 32'h1);
    rd(6'h02, r);
    #2 reset_n = 1'b0;
    #1;
    chk("async hit", 32'(pixel_hit), 32'h0);
    chk("async col", 32'(pixel_color), 32'h0);
    chk("async dout", 32'(data_out), 32'h0);
    @(negedge raw_clk);
    reset_n = 1'b1;
    rd(6'h00, r); chk("post posx", 32'(r), 32'h0);
    rd(6'h02, r); chk("post gfx", 32'(r), 32'h0);
    rd(6'h03, r); chk("post col", 32'(r), 32'h0);
    rd(6'h20, r); chk("post en", 32'(r), 32'h0);
    rd(6'h21, r); chk("post bg", 32'(r), 32'h0);
    for (int x = 105; x <= 107; x++) pix_obj0(x, 1'b0, 7'h00);
    pix_obj0(0, 1'b0, 7'h00);

    // Unmapped and nonexistent-object accesses
    wr(6'h10, 8'hFF);
    rd(6'h10, r); chk("obj4 rd", 32'(r), 32'h0);
    rd(6'h23, r); chk("unmapped rd", 32'(r), 32'h0);

    // Vertical delay: vdel=1 object, graphics written before the trigger
    wr(6'h00, 8'h64); wr(6'h02, 8'hA5); wr(6'h01, 8'h80); wr(6'h03, 8'h82);
    wr(6'h21, 8'h10); wr(6'h20, 8'h01);
    rd(6'h01, r); chk("vdel rd", 32'(r), 32'h80);
    line();
    for (int x = 100; x <= 107; x++) pix_obj0(x, msb_bit(8'hA5, x - 100), BG);
    line();
    pix(50);
    wr(6'h02, 8'h0F);
`ifdef OBJECT_ENGINE_VDELAY_EN
    pat = 8'hA5;
`else
    pat = 8'h0F;
`endif
    for (int x = 100; x <= 107; x++) pix_obj0(x, msb_bit(pat, x - 100), BG);
    line();
    for (int x = 100; x <= 107; x++) pix_obj0(x, msb_bit(8'h0F, x - 100), BG);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
